// File: rtl/gradient_config_ctrl.sv
// Gradient configuration controller: stages colours/direction from button pulses and
// commits them to the active set at frame start, with a post-commit frame lock and auto swap.
module gradient_config_ctrl #(
  parameter int CW          = 4,
  parameter int LOCK_FRAMES = 2,
  parameter int AUTO_FRAMES = 60
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [CW-1:0]     R,
  input  logic [CW-1:0]     G,
  input  logic [CW-1:0]     B,
  input  logic              push_a,
  input  logic              push_b,
  input  logic              h_push,
  input  logic              v_push,
  input  logic              swap_push,
  input  logic              auto_en,
  input  logic              frame_start,
  output logic [3*CW-1:0]   start_color,
  output logic [3*CW-1:0]   end_color,
  output logic              dir,
  output logic              pending,
  output logic              update,
  output logic [7:0]        lock_cnt
);

  localparam int W   = 3 * CW;
  localparam int ACW = $clog2(AUTO_FRAMES);

  typedef enum logic [1:0] {IDLE, WAIT, COMMIT, LOCK} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   stg_start_q, stg_start_d, stg_end_q, stg_end_d;
  logic           stg_dir_q, stg_dir_d;
  logic [W-1:0]   act_start_q, act_start_d, act_end_q, act_end_d;
  logic           act_dir_q, act_dir_d;
  logic           update_q, update_d;
  logic [7:0]     lock_cnt_q, lock_cnt_d;
  logic [ACW-1:0] auto_cnt_q, auto_cnt_d;

  logic [W-1:0]   rgb, pushed_start, pushed_end;
  logic           auto_swap;

  assign rgb = {R, G, B};

  // Staging path and auto-swap frame counter
  always_comb begin
    auto_cnt_d = auto_cnt_q;
    auto_swap  = 1'b0;
    if (!auto_en) begin
      auto_cnt_d = '0;
    end else if (frame_start) begin
      if (auto_cnt_q == ACW'(AUTO_FRAMES - 1)) begin
        auto_cnt_d = '0;
        auto_swap  = 1'b1;
      end else begin
        auto_cnt_d = auto_cnt_q + ACW'(1);
      end
    end

    pushed_start = push_a ? rgb : stg_start_q;
    pushed_end   = push_b ? rgb : stg_end_q;
    // Pushes land first, then a (single) swap, whether user or auto initiated
    if (swap_push || auto_swap) begin
      stg_start_d = pushed_end;
      stg_end_d   = pushed_start;
    end else begin
      stg_start_d = pushed_start;
      stg_end_d   = pushed_end;
    end

    if (h_push)      stg_dir_d = 1'b0;
    else if (v_push) stg_dir_d = 1'b1;
    else             stg_dir_d = stg_dir_q;
  end

  assign pending = (stg_start_q != act_start_q) || (stg_end_q != act_end_q) ||
                   (stg_dir_q != act_dir_q);

  always_comb begin
    state_d     = state_q;
    lock_cnt_d  = lock_cnt_q;
    act_start_d = act_start_q;
    act_end_d   = act_end_q;
    act_dir_d   = act_dir_q;
    update_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (pending) state_d = frame_start ? COMMIT : WAIT;
      end
      WAIT: begin
        if (!pending)         state_d = IDLE;
        else if (frame_start) state_d = COMMIT;
      end
      COMMIT: begin
        // Take next-staging so an edit landing in this very cycle is not lost
        act_start_d = stg_start_d;
        act_end_d   = stg_end_d;
        act_dir_d   = stg_dir_d;
        update_d    = 1'b1;
        lock_cnt_d  = 8'(LOCK_FRAMES);
        state_d     = LOCK;
      end
      LOCK: begin
        if (frame_start) begin
          if (lock_cnt_q <= 8'd1) begin
            lock_cnt_d = 8'd0;
            state_d    = pending ? WAIT : IDLE;
          end else begin
            lock_cnt_d = lock_cnt_q - 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      stg_start_q <= '0;
      stg_end_q   <= '1;
      stg_dir_q   <= 1'b0;
      act_start_q <= '0;
      act_end_q   <= '1;
      act_dir_q   <= 1'b0;
      update_q    <= 1'b0;
      lock_cnt_q  <= 8'd0;
      auto_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      stg_start_q <= stg_start_d;
      stg_end_q   <= stg_end_d;
      stg_dir_q   <= stg_dir_d;
      act_start_q <= act_start_d;
      act_end_q   <= act_end_d;
      act_dir_q   <= act_dir_d;
      update_q    <= update_d;
      lock_cnt_q  <= lock_cnt_d;
      auto_cnt_q  <= auto_cnt_d;
    end
  end

  assign start_color = act_start_q;
  assign end_color   = act_end_q;
  assign dir         = act_dir_q;
  assign update      = update_q;
  assign lock_cnt    = lock_cnt_q;

endmodule

// File: tb/tb_gradient_config_ctrl.sv
// Directed bench for gradient_config_ctrl: expected commits are queued at the frame_start
// that should trigger them and compared whenever the DUT strobes update.
module tb_gradient_config_ctrl;

  logic        clock;
  logic        reset;
  logic [3:0]  R, G, B;
  logic        push_a, push_b, h_push, v_push, swap_push, auto_en, frame_start;
  logic [11:0] start_color, end_color;
  logic        dir, pending, update;
  logic [7:0]  lock_cnt;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [11:0] s;
    logic [11:0] e;
    logic        d;
  } exp_t;
  exp_t exp_q[$];

  gradient_config_ctrl #(.CW(4), .LOCK_FRAMES(2), .AUTO_FRAMES(4)) dut (
    .clock(clock), .reset(reset), .R(R), .G(G), .B(B),
    .push_a(push_a), .push_b(push_b), .h_push(h_push), .v_push(v_push),
    .swap_push(swap_push), .auto_en(auto_en), .frame_start(frame_start),
    .start_color(start_color), .end_color(end_color), .dir(dir),
    .pending(pending), .update(update), .lock_cnt(lock_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_rgb(input logic [11:0] c);
    {R, G, B} = c;
  endtask

  task automatic do_push_a(input logic [11:0] c);
    set_rgb(c); push_a = 1'b1; tick(); push_a = 1'b0;
  endtask

  task automatic do_push_b(input logic [11:0] c);
    set_rgb(c); push_b = 1'b1; tick(); push_b = 1'b0;
  endtask

  task automatic frame();
    frame_start = 1'b1; tick(); frame_start = 1'b0;
  endtask

  task automatic expect_commit(input logic [11:0] s, input logic [11:0] e, input logic d);
    exp_t x;
    x.s = s; x.e = e; x.d = d;
    exp_q.push_back(x);
  endtask

  // Call in the COMMIT cycle: next cycle must carry update and the reloaded lock count
  task automatic commit_check(input string tag);
    tick();
    check({tag, "_update"}, 32'(update), 32'd1);
    check({tag, "_lock"}, 32'(lock_cnt), 32'd2);
    check({tag, "_pending"}, 32'(pending), 32'd0);
    tick();
    check({tag, "_update_drop"}, 32'(update), 32'd0);
  endtask

  task automatic unlock(input string tag);
    tick(); frame(); tick(); frame(); tick();
    check({tag, "_unlocked"}, 32'(lock_cnt), 32'd0);
  endtask

  // Scoreboard side: every update strobe must match the oldest queued commit
  always @(negedge clock) begin
    if (reset === 1'b1 && update === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("update_unexpected", 32'(update), 32'd0);
      end else begin
        exp_t x;
        x = exp_q.pop_front();
        check("sb_start", 32'(start_color), 32'(x.s));
        check("sb_end", 32'(end_color), 32'(x.e));
        check("sb_dir", 32'(dir), 32'(x.d));
      end
    end
  end

  initial begin
    reset = 1'b0;
    {R, G, B} = 12'h000;
    push_a = 0; push_b = 0; h_push = 0; v_push = 0; swap_push = 0;
    auto_en = 0; frame_start = 0;
    tick(); tick();
    check("rst_start", 32'(start_color), 32'h000);
    check("rst_end", 32'(end_color), 32'hFFF);
    check("rst_dir", 32'(dir), 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_update", 32'(update), 32'd0);
    check("rst_lock", 32'(lock_cnt), 32'd0);
    reset = 1'b1;

    // Idle frames with nothing staged
    for (int i = 0; i < 3; i++) begin tick(); frame(); end
    tick();
    check("idle_start", 32'(start_color), 32'h000);
    check("idle_end", 32'(end_color), 32'hFFF);
    check("idle_pending", 32'(pending), 32'd0);

    // push_a F00, frame_start five cycles later
    do_push_a(12'hF00);
    check("t2_pending", 32'(pending), 32'd1);
    for (int i = 0; i < 4; i++) tick();
    check("t2_pending_hold", 32'(pending), 32'd1);
    expect_commit(12'hF00, 12'hFFF, 1'b0);
    frame();
    check("t2_commit_cycle_old", 32'(start_color), 32'h000);
    check("t2_commit_cycle_pend", 32'(pending), 32'd1);
    commit_check("t2");

    // v_push during lock: frames only count down
    v_push = 1'b1; tick(); v_push = 1'b0;
    check("t3_pending", 32'(pending), 32'd1);
    frame();
    check("t3_lock1", 32'(lock_cnt), 32'd1);
    check("t3_dir_held1", 32'(dir), 32'd0);
    tick(); tick();
    frame();
    check("t3_lock0", 32'(lock_cnt), 32'd0);
    check("t3_dir_held2", 32'(dir), 32'd0);
    tick(); tick();
    expect_commit(12'hF00, 12'hFFF, 1'b1);
    frame();
    commit_check("t3");
    unlock("t3");

    // h_push and v_push together: H wins
    h_push = 1'b1; v_push = 1'b1; tick(); h_push = 1'b0; v_push = 1'b0;
    check("t4_hv_pending", 32'(pending), 32'd1);
    expect_commit(12'hF00, 12'hFFF, 1'b0);
    frame();
    commit_check("t4_hv");
    unlock("t4_hv");

    // push_a 0F0, then push_b 00F landing in the COMMIT cycle itself
    do_push_a(12'h0F0);
    expect_commit(12'h0F0, 12'h00F, 1'b0);
    frame();
    set_rgb(12'h00F); push_b = 1'b1;
    commit_check("t4_commit_push");
    push_b = 1'b0;
    unlock("t4_ab");

    // Same-cycle push_a+push_b with frame_start: that frame_start is not a commit trigger
    set_rgb(12'hABC); push_a = 1'b1; push_b = 1'b1; frame_start = 1'b1;
    tick();
    push_a = 1'b0; push_b = 1'b0; frame_start = 1'b0;
    tick(); tick(); tick();
    check("t4_nocommit_start", 32'(start_color), 32'h0F0);
    check("t4_nocommit_pend", 32'(pending), 32'd1);
    expect_commit(12'hABC, 12'hABC, 1'b0);
    frame();
    commit_check("t4_both");
    unlock("t4_both");

    // push_b with swap_push in one cycle: push first, then swap
    do_push_a(12'h0F0);
    set_rgb(12'h00F); push_b = 1'b1; swap_push = 1'b1; tick();
    push_b = 1'b0; swap_push = 1'b0;
    expect_commit(12'h00F, 12'h0F0, 1'b0);
    frame();
    commit_check("t4_swap");
    unlock("t4_swap");

    // Auto swap every 4 frames
    do_push_a(12'h123);
    do_push_b(12'h456);
    expect_commit(12'h123, 12'h456, 1'b0);
    frame();
    commit_check("t5_setup");
    unlock("t5_setup");
    auto_en = 1'b1;
    for (int i = 0; i < 3; i++) begin tick(); frame(); end
    check("t5_no_swap_yet", 32'(pending), 32'd0);
    tick(); frame();
    check("t5_swapped_pend", 32'(pending), 32'd1);
    check("t5_swapped_active", 32'(start_color), 32'h123);
    tick();
    expect_commit(12'h456, 12'h123, 1'b0);
    frame();
    commit_check("t5_auto");
    auto_en = 1'b0;
    unlock("t5_auto");

    // User swap coinciding with auto swap collapses to one swap
    auto_en = 1'b1;
    for (int i = 0; i < 3; i++) begin tick(); frame(); end
    tick();
    swap_push = 1'b1; frame_start = 1'b1; tick(); swap_push = 1'b0; frame_start = 1'b0;
    check("t5_single_swap_pend", 32'(pending), 32'd1);
    tick();
    expect_commit(12'h123, 12'h456, 1'b0);
    frame();
    auto_en = 1'b0;
    commit_check("t5_single");
    unlock("t5_single");

    // Reset asserted in the COMMIT cycle: no commit, no strobe
    do_push_a(12'h777);
    frame();
    reset = 1'b0;
    #1;
    check("t6c_start", 32'(start_color), 32'h000);
    check("t6c_pending", 32'(pending), 32'd0);
    check("t6c_update", 32'(update), 32'd0);
    tick(); tick();
    reset = 1'b1;
    tick(); tick(); tick();
    check("t6c_after_start", 32'(start_color), 32'h000);
    check("t6c_after_update", 32'(update), 32'd0);

    // Reset asserted during LOCK
    do_push_a(12'h777);
    expect_commit(12'h777, 12'hFFF, 1'b0);
    frame();
    commit_check("t6l");
    reset = 1'b0;
    #1;
    check("t6l_lock", 32'(lock_cnt), 32'd0);
    check("t6l_start", 32'(start_color), 32'h000);
    check("t6l_end", 32'(end_color), 32'hFFF);
    check("t6l_dir", 32'(dir), 32'd0);
    check("t6l_update", 32'(update), 32'd0);
    tick();
    reset = 1'b1;
    tick(); tick();
    check("t6l_after_update", 32'(update), 32'd0);
    check("t6l_after_pending", 32'(pending), 32'd0);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
